// File: rtl/alien_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// alien_pkg : shared invader-matrix geometry, fire-selector state type, LFSR step
// Revision  : 1.0
// -----------------------------------------------------------------------------
package alien_pkg;

  localparam int DEF_ROWS   = 5;
  localparam int DEF_COLS   = 11;
  localparam int DEF_CELL_W = 32;
  localparam int DEF_CELL_H = 32;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    EMIT     = 2'd2,
    COOLDOWN = 2'd3
  } fire_sel_state_t;

  // Fibonacci step for x^16 + x^14 + x^13 + x^11 + 1
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alien_fire_selector_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// alien_fire_selector_if : game-side inputs and shot-spawn outputs of the selector
// Revision               : 1.0
// -----------------------------------------------------------------------------
interface alien_fire_selector_if
  import alien_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);

  logic                   startOfFrame;
  logic                   standBy;
  logic                   gameEnded;
  logic                   fireAlive;
  logic [ROWS*COLS-1:0]   aliensAlive;
  logic [10:0]            matrixTLX;
  logic [10:0]            matrixTLY;
  logic [10:0]            alienXPosition;
  logic [10:0]            alienYPosition;
  logic                   bottomAlien;
  logic                   noAliens;

  modport master (
    output startOfFrame, standBy, gameEnded, fireAlive, aliensAlive, matrixTLX, matrixTLY,
    input  alienXPosition, alienYPosition, bottomAlien, noAliens
  );

  modport slave (
    input  startOfFrame, standBy, gameEnded, fireAlive, aliensAlive, matrixTLX, matrixTLY,
    output alienXPosition, alienYPosition, bottomAlien, noAliens
  );

endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lfsr16   : free-running 16-bit Fibonacci LFSR, advances every clock
// Revision : 1.0
// -----------------------------------------------------------------------------
module lfsr16
  import alien_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= SEED;
    end else begin
      state <= lfsr16_next(state);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alien_fire_selector.sv
`default_nettype none
// -----------------------------------------------------------------------------
// alien_fire_selector : picks the lowest living alien of a random column and
//                       emits its muzzle position with a one-clock pulse
// Revision            : 1.0
// -----------------------------------------------------------------------------
module alien_fire_selector
  import alien_pkg::*;
#(
  parameter int ROWS            = DEF_ROWS,
  parameter int COLS            = DEF_COLS,
  parameter int CELL_W          = DEF_CELL_W,
  parameter int CELL_H          = DEF_CELL_H,
  parameter int SHOT_OFFSET_X   = 15,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  resetN,
  alien_fire_selector_if.slave  bus
);

  localparam int N     = ROWS * COLS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = $clog2(COLS);
  localparam int IDX_W = $clog2(N);

  localparam logic [ROW_W-1:0] ROW_TOP  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  fire_sel_state_t   state;
  logic [15:0]       lfsr;
  logic [N-1:0]      alive_snap;
  logic [10:0]       tlx_snap;
  logic [10:0]       tly_snap;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  cols_done;
  logic [15:0]       cooldown;
  logic [10:0]       x_pos;
  logic [10:0]       y_pos;
  logic              pulse;
  logic              none_found;

  logic              play;
  logic [4:0]        lfsr_col;
  logic [COL_W-1:0]  start_col;
  logic [IDX_W-1:0]  idx;
  logic              cell_alive;
  logic [10:0]       x_next;
  logic [10:0]       y_next;
  logic              unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .state  (lfsr)
  );

  assign play        = ~(bus.standBy | bus.gameEnded);
  assign unused_lfsr = ^lfsr[15:4];

  // A 4-bit draw never exceeds 2*COLS-1 for COLS >= 8, so one subtraction folds it
  assign lfsr_col  = {1'b0, lfsr[3:0]};
  assign start_col = COL_W'((lfsr_col >= 5'(COLS)) ? (lfsr_col - 5'(COLS)) : lfsr_col);

  assign idx        = IDX_W'(int'(row) * COLS + int'(col));
  assign cell_alive = alive_snap[idx];

  assign x_next = tlx_snap + 11'(col) * 11'(CELL_W) + 11'(SHOT_OFFSET_X);
  assign y_next = tly_snap + (11'(row) + 11'd1) * 11'(CELL_H);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      alive_snap <= '0;
      tlx_snap   <= '0;
      tly_snap   <= '0;
      row        <= '0;
      col        <= '0;
      cols_done  <= '0;
      cooldown   <= '0;
      x_pos      <= '0;
      y_pos      <= '0;
      pulse      <= 1'b0;
      none_found <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.startOfFrame && play && !bus.fireAlive) begin
            alive_snap <= bus.aliensAlive;
            tlx_snap   <= bus.matrixTLX;
            tly_snap   <= bus.matrixTLY;
            col        <= start_col;
            row        <= ROW_TOP;
            cols_done  <= '0;
            state      <= SCAN;
          end
        end

        SCAN: begin
          if (!play) begin
            state <= IDLE;
          end else if (cell_alive) begin
            // Outputs are loaded here so they are already valid in the EMIT clock
            x_pos      <= x_next;
            y_pos      <= y_next;
            pulse      <= 1'b1;
            none_found <= 1'b0;
            state      <= EMIT;
          end else if (row == '0) begin
            row <= ROW_TOP;
            col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
            if (cols_done == COL_LAST) begin
              none_found <= 1'b1;
              state      <= IDLE;
            end else begin
              cols_done <= cols_done + COL_W'(1);
            end
          end else begin
            row <= row - ROW_W'(1);
          end
        end

        EMIT: begin
          cooldown <= 16'(COOLDOWN_FRAMES);
          state    <= COOLDOWN;
        end

        COOLDOWN: begin
          if (!play || cooldown == '0) begin
            state <= IDLE;
          end else if (bus.startOfFrame) begin
            cooldown <= cooldown - 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alienXPosition = x_pos;
  assign bus.alienYPosition = y_pos;
  assign bus.bottomAlien    = pulse;
  assign bus.noAliens       = none_found;

endmodule
`default_nettype wire

// File: tb/tb_alien_fire_selector.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_alien_fire_selector : directed and random checks of alien_fire_selector
// Revision               : 1.0
// -----------------------------------------------------------------------------
module tb_alien_fire_selector;
  import alien_pkg::*;

  localparam int ROWS = 5;
  localparam int COLS = 11;
  localparam int BUDGET = 70;

  logic clk;
  logic resetN;
  int   errors;
  int   checks;

  alien_fire_selector_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  alien_fire_selector #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .CELL_W          (32),
    .CELL_H          (32),
    .SHOT_OFFSET_X   (15),
    .COOLDOWN_FRAMES (3)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random source the DUT should be drawing from
  logic [15:0] model_lfsr;
  always @(posedge clk or negedge resetN) begin
    if (!resetN) model_lfsr <= 16'hACE1;
    else         model_lfsr <= {model_lfsr[14:0], ^(model_lfsr & 16'hB400)};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bottom-up per column, columns in order from c0 with wrap
  function automatic void ref_scan(input logic [ROWS*COLS-1:0] alive, input int c0,
                                   output bit found, output int k, output int r, output int c);
    int step;
    step = 0; found = 0; k = 0; r = 0; c = 0;
    for (int i = 0; i < COLS; i++) begin
      for (int rr = ROWS - 1; rr >= 0; rr--) begin
        if (!found && alive[rr * COLS + (c0 + i) % COLS]) begin
          found = 1; k = step; r = rr; c = (c0 + i) % COLS;
        end
        step++;
      end
    end
  endfunction

  task automatic run_frame(output bit seen, output int n, output int c0);
    int raw;
    raw = int'(model_lfsr[3:0]);
    c0  = (raw >= COLS) ? raw - COLS : raw;
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    seen = 0;
    n    = 0;
    for (int i = 1; i <= BUDGET; i++) begin
      if (bus.bottomAlien) begin
        seen = 1;
        n    = i;
        break;
      end
      tick();
    end
    if (seen) begin
      tick();
      check("pulse_width", 32'(bus.bottomAlien), 0);
    end
  endtask

  task automatic drain_cooldown();
    bus.fireAlive = 1'b1;
    repeat (3) begin
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      tick();
      tick();
    end
    tick();
    bus.fireAlive = 1'b0;
  endtask

  bit                    seen;
  bit                    found;
  int                    n;
  int                    c0;
  int                    k;
  int                    r;
  int                    c;
  int                    tlx;
  int                    tly;
  logic [ROWS*COLS-1:0]  pattern;

  initial begin
    errors = 0;
    checks = 0;
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.standBy      = 1'b0;
    bus.gameEnded    = 1'b0;
    bus.fireAlive    = 1'b0;
    bus.aliensAlive  = '0;
    bus.matrixTLX    = '0;
    bus.matrixTLY    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_x", 32'(bus.alienXPosition), 0);
    check("reset_y", 32'(bus.alienYPosition), 0);
    check("reset_pulse", 32'(bus.bottomAlien), 0);
    check("reset_noaliens", 32'(bus.noAliens), 0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    resetN = 1'b1;
    tick();

    // Single alien at row 2 / col 7
    pattern = '0;
    pattern[2 * COLS + 7] = 1'b1;
    bus.aliensAlive = pattern;
    bus.matrixTLX = 11'd100;
    bus.matrixTLY = 11'd50;
    run_frame(seen, n, c0);
    ref_scan(pattern, c0, found, k, r, c);
    check("single_seen", 32'(seen), 1);
    check("single_latency", 32'(n), 32'(k + 2));
    check("single_x", 32'(bus.alienXPosition), 339);
    check("single_y", 32'(bus.alienYPosition), 146);
    check("single_noaliens", 32'(bus.noAliens), 0);
    drain_cooldown();

    // Column 7, rows 0 and 4: lowest wins
    pattern = '0;
    pattern[0 * COLS + 7] = 1'b1;
    pattern[4 * COLS + 7] = 1'b1;
    bus.aliensAlive = pattern;
    run_frame(seen, n, c0);
    ref_scan(pattern, c0, found, k, r, c);
    check("lowest_seen", 32'(seen), 1);
    check("lowest_latency", 32'(n), 32'(k + 2));
    check("lowest_x", 32'(bus.alienXPosition), 339);
    check("lowest_y", 32'(bus.alienYPosition), 210);
    drain_cooldown();

    // Empty matrix
    bus.aliensAlive = '0;
    run_frame(seen, n, c0);
    check("empty_seen", 32'(seen), 0);
    check("empty_noaliens", 32'(bus.noAliens), 1);
    check("empty_state", 32'(dut.state), 32'(IDLE));
    check("empty_x_hold", 32'(bus.alienXPosition), 339);

    // Asynchronous reset in the middle of a scan
    pattern = '0;
    for (int cc = 0; cc < COLS; cc++) pattern[cc] = 1'b1;
    bus.aliensAlive = pattern;
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    tick();
    resetN = 1'b0;
    #1;
    check("midreset_x", 32'(bus.alienXPosition), 0);
    check("midreset_y", 32'(bus.alienYPosition), 0);
    check("midreset_pulse", 32'(bus.bottomAlien), 0);
    check("midreset_noaliens", 32'(bus.noAliens), 0);
    check("midreset_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk);
    #1;
    resetN = 1'b1;
    tick();

    // Shot in flight blocks selection
    pattern = '0;
    pattern[2 * COLS + 7] = 1'b1;
    bus.aliensAlive = pattern;
    bus.fireAlive = 1'b1;
    for (int f = 0; f < 5; f++) begin
      run_frame(seen, n, c0);
      check($sformatf("inflight_%0d", f), 32'(seen), 0);
    end
    bus.fireAlive = 1'b0;
    run_frame(seen, n, c0);
    ref_scan(pattern, c0, found, k, r, c);
    check("after_inflight_seen", 32'(seen), 1);
    check("after_inflight_latency", 32'(n), 32'(k + 2));

    // Cooldown of 3 frames: SOFs 1..3 are swallowed, the 4th fires
    for (int f = 1; f <= 3; f++) begin
      run_frame(seen, n, c0);
      check($sformatf("cooldown_sof%0d", f), 32'(seen), 0);
    end
    run_frame(seen, n, c0);
    check("cooldown_sof4", 32'(seen), 1);
    drain_cooldown();

    // Standby mid-scan aborts
    pattern = '0;
    for (int cc = 0; cc < COLS; cc++) pattern[cc] = 1'b1;
    bus.aliensAlive = pattern;
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    bus.standBy = 1'b1;
    tick();
    bus.standBy = 1'b0;
    seen = 0;
    for (int i = 0; i < BUDGET; i++) begin
      if (bus.bottomAlien) seen = 1;
      tick();
    end
    check("standby_seen", 32'(seen), 0);
    check("standby_state", 32'(dut.state), 32'(IDLE));

    // X wraps at 2048
    pattern = '0;
    pattern[4 * COLS + 0] = 1'b1;
    bus.aliensAlive = pattern;
    bus.matrixTLX = 11'd2040;
    bus.matrixTLY = 11'd50;
    run_frame(seen, n, c0);
    check("wrap_seen", 32'(seen), 1);
    check("wrap_x", 32'(bus.alienXPosition), 7);
    check("wrap_y", 32'(bus.alienYPosition), 210);
    drain_cooldown();

    // Random populations and matrix positions
    for (int it = 0; it < 10; it++) begin
      pattern = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if (it == 0) pattern = '0;
      tlx = int'($urandom_range(0, 2047));
      tly = int'($urandom_range(0, 2047));
      bus.aliensAlive = pattern;
      bus.matrixTLX = 11'(tlx);
      bus.matrixTLY = 11'(tly);
      run_frame(seen, n, c0);
      ref_scan(pattern, c0, found, k, r, c);
      check($sformatf("rand%0d_seen", it), 32'(seen), 32'(found));
      check($sformatf("rand%0d_noaliens", it), 32'(bus.noAliens), 32'(!found));
      if (found) begin
        check($sformatf("rand%0d_latency", it), 32'(n), 32'(k + 2));
        check($sformatf("rand%0d_x", it), 32'(bus.alienXPosition), 32'((tlx + c * 32 + 15) % 2048));
        check($sformatf("rand%0d_y", it), 32'(bus.alienYPosition), 32'((tly + (r + 1) * 32) % 2048));
        drain_cooldown();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
